// File: rtl/femto_reset_pkg.sv
// Shared types and constants for the femto reset sequencer.
package femto_reset_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_WAIT_LOCK = 2'd0,
    S_FILTER    = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam int                LOSS_W   = 8;
  localparam logic [LOSS_W-1:0] LOSS_SAT = 8'd255;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/femto_sync2.sv
// Two-flop synchronizer with synchronous active-high clear.
module femto_sync2 (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state always uses non-blocking assignments so both flops
  // sample their inputs from the same edge and the chain really is two deep.
  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/femto_reset_seq.sv
// Reset sequencer: filters PLL lock, holds reset off, tracks lock losses.
// Optional debounced reset button is enabled with `define FEMTO_RST_BTN_EN.
module femto_reset_seq
  import femto_reset_pkg::*;
#(
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 1024
`ifdef FEMTO_RST_BTN_EN
  ,
  parameter int DEBOUNCE_CYCLES = 65536
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pll_locked,
`ifdef FEMTO_RST_BTN_EN
  input  logic              btn_n,
`endif
  output logic              sys_reset,
  output logic              sys_resetn,
  output logic              ready,
  output logic [STATE_W-1:0] seq_state,
  output logic [LOSS_W-1:0] lock_loss_cnt
);

  localparam int CNT_W = $clog2(max2(LOCK_FILTER, HOLD_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             locked_s;
  logic             loss_inc;
  logic             force_wait;

  femto_sync2 u_sync_lock (
    .clk (clk),
    .clr (reset),
    .d   (pll_locked),
    .q   (locked_s)
  );

`ifdef FEMTO_RST_BTN_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            pressed_s;
  logic            btn_db;
  logic [DB_W-1:0] db_cnt;

  // Synchronize the pressed sense so a cleared synchronizer reads "released".
  femto_sync2 u_sync_btn (
    .clk (clk),
    .clr (reset),
    .d   (~btn_n),
    .q   (pressed_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (pressed_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= pressed_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign force_wait = btn_db;
`else
  assign force_wait = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    loss_inc   = 1'b0;
    case (state)
      S_WAIT_LOCK: begin
        if (locked_s) begin
          next_state = S_FILTER;
          next_cnt   = '0;
        end
      end
      S_FILTER: begin
        if (!locked_s) begin
          next_state = S_WAIT_LOCK;
          next_cnt   = '0;
        end else if (cnt == FILTER_LAST) begin
          next_state = S_HOLD;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (!locked_s) begin
          next_state = S_WAIT_LOCK;
          next_cnt   = '0;
        end else if (cnt == HOLD_LAST) begin
          next_state = S_RUN;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          next_state = S_WAIT_LOCK;
          next_cnt   = '0;
          loss_inc   = 1'b1;
        end
      end
      default: begin
        next_state = S_WAIT_LOCK;
        next_cnt   = '0;
      end
    endcase

    // A button press overrides everything and is not a lock loss.
    if (force_wait) begin
      next_state = S_WAIT_LOCK;
      next_cnt   = '0;
      loss_inc   = 1'b0;
    end
  end

  // Outputs come from next_state so they move on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_WAIT_LOCK;
      cnt           <= '0;
      sys_reset     <= 1'b1;
      sys_resetn    <= 1'b0;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      sys_reset  <= (next_state != S_RUN);
      sys_resetn <= (next_state == S_RUN);
      ready      <= (next_state == S_RUN);
      if (loss_inc && (lock_loss_cnt != LOSS_SAT)) begin
        lock_loss_cnt <= lock_loss_cnt + LOSS_W'(1);
      end
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_femto_reset_seq.sv
// Self-checking bench for femto_reset_seq (LOCK_FILTER=4, HOLD_CYCLES=8).
// Button scenario runs only when FEMTO_RST_BTN_EN is defined.
module tb_femto_reset_seq;

  localparam int LF   = 4;
  localparam int HOLD = 8;
  localparam int DEB  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       btn_n = 1'b1;
  logic       sys_reset, sys_resetn, ready;
  logic [1:0] seq_state;
  logic [7:0] lock_loss_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  femto_reset_seq #(
    .LOCK_FILTER (LF),
    .HOLD_CYCLES (HOLD)
`ifdef FEMTO_RST_BTN_EN
    ,
    .DEBOUNCE_CYCLES (DEB)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pll_locked    (pll_locked),
`ifdef FEMTO_RST_BTN_EN
    .btn_n         (btn_n),
`endif
    .sys_reset     (sys_reset),
    .sys_resetn    (sys_resetn),
    .ready         (ready),
    .seq_state     (seq_state),
    .lock_loss_cnt (lock_loss_cnt)
  );

  // Behavioural model: the sequence is a function of how long the
  // synchronized lock has been continuously high (lock_run edges).
  // 0 -> waiting, 1..LF -> filtering, up to LF+HOLD -> holding, beyond -> running.
  logic m_valid = 1'b0;
  logic m_pipe1, m_pipe2;
  int   lock_run;
  int   m_loss;
  logic b_pipe1, b_pipe2;
  logic m_db;
  int   m_db_run;

  function automatic int exp_state(input int run);
    if (run == 0) return 0;
    if (run <= LF) return 1;
    if (run <= LF + HOLD) return 2;
    return 3;
  endfunction

  always @(posedge clk) begin
    logic ls, ps, was_run;
    if (reset) begin
      m_valid  = 1'b1;
      m_pipe1  = 1'b0;
      m_pipe2  = 1'b0;
      lock_run = 0;
      m_loss   = 0;
      b_pipe1  = 1'b0;
      b_pipe2  = 1'b0;
      m_db     = 1'b0;
      m_db_run = 0;
    end else if (m_valid) begin
      ls      = m_pipe2;
      m_pipe2 = m_pipe1;
      m_pipe1 = pll_locked;
      was_run = (exp_state(lock_run) == 3);
`ifdef FEMTO_RST_BTN_EN
      if (m_db) begin
        lock_run = 0;
      end else
`endif
      if (!ls) begin
        if (was_run && m_loss < 255) m_loss = m_loss + 1;
        lock_run = 0;
      end else if (lock_run <= LF + HOLD) begin
        lock_run = lock_run + 1;
      end
      ps      = b_pipe2;
      b_pipe2 = b_pipe1;
      b_pipe1 = ~btn_n;
      if (ps != m_db) begin
        m_db_run = m_db_run + 1;
        if (m_db_run == DEB) begin
          m_db     = ps;
          m_db_run = 0;
        end
      end else begin
        m_db_run = 0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    int es;
    logic er;
    #1;
    if (m_valid) begin
      es = exp_state(lock_run);
      er = (es != 3);
      vectors = vectors + 1;
      if (seq_state !== 2'(es) || sys_reset !== er || sys_resetn !== ~er ||
          ready !== ~er || lock_loss_cnt !== 8'(m_loss)) begin
        miscompares = miscompares + 1;
        $display("FAIL model t=%0t: got state=%0d rst=%b rstn=%b rdy=%b loss=%0d, want state=%0d rst=%b rstn=%b rdy=%b loss=%0d",
                 $time, seq_state, sys_reset, sys_resetn, ready, lock_loss_cnt,
                 es, er, ~er, ~er, m_loss);
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lock(input logic v);
    @(negedge clk);
    pll_locked = v;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    pll_locked = 1'b0;
    step(n);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // 1: clean release, lock first sampled at E.
    step(3);
    check("reset_state", seq_state, 0);
    check("reset_sys_reset", sys_reset, 1);
    check("reset_ready", ready, 0);
    check("reset_loss", lock_loss_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    set_lock(1'b1);
    step(14);
    check("t1_rst_at_E13", sys_reset, 1);
    step(1);
    check("t1_rst_at_E14", sys_reset, 0);
    check("t1_rstn_at_E14", sys_resetn, 1);
    check("t1_ready_at_E14", ready, 1);
    check("t1_state_at_E14", seq_state, 3);

    // 2: glitchy lock aborts the filter.
    do_reset(2);
    pll_locked = 1'b1;
    step(4);
    check("t2_in_filter", seq_state, 1);
    @(negedge clk);
    pll_locked = 1'b0;
    step(3);
    check("t2_abort", seq_state, 0);
    set_lock(1'b1);
    step(14);
    check("t2_rst_at_F13", sys_reset, 1);
    step(1);
    check("t2_rst_at_F14", sys_reset, 0);
    check("t2_loss", lock_loss_cnt, 0);

    // 3: lock loss in RUN.
    set_lock(1'b0);
    step(2);
    check("t3_rst_at_G1", sys_reset, 0);
    step(1);
    check("t3_rst_at_G2", sys_reset, 1);
    check("t3_ready_at_G2", ready, 0);
    check("t3_state_at_G2", seq_state, 0);
    check("t3_loss", lock_loss_cnt, 1);

    // 4: saturation of the loss counter.
    for (int i = 0; i < 260; i++) begin
      set_lock(1'b1);
      step(16);
      set_lock(1'b0);
      step(3);
    end
    check("t4_sat", lock_loss_cnt, 255);
    set_lock(1'b1);
    step(16);
    set_lock(1'b0);
    step(3);
    check("t4_sat_hold", lock_loss_cnt, 255);

    // 5: reset during HOLD at cnt=5 (edge E+11), lock held throughout.
    set_lock(1'b1);
    step(12);
    check("t5_in_hold", seq_state, 2);
    @(negedge clk);
    reset = 1'b1;
    step(1);
    check("t5_state", seq_state, 0);
    check("t5_rst", sys_reset, 1);
    check("t5_loss", lock_loss_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    step(14);
    check("t5_rst_at_13", sys_reset, 1);
    step(1);
    check("t5_rst_at_14", sys_reset, 0);

`ifdef FEMTO_RST_BTN_EN
    // 6: short press ignored, long press forces reset until release debounces.
    @(negedge clk);
    btn_n = 1'b0;
    repeat (10) @(negedge clk);
    btn_n = 1'b1;
    step(30);
    check("t6_short_rst", sys_reset, 0);
    check("t6_short_state", seq_state, 3);
    @(negedge clk);
    btn_n = 1'b0;
    step(18);
    check("t6_rst_at_B17", sys_reset, 0);
    step(1);
    check("t6_rst_at_B18", sys_reset, 1);
    step(21);
    @(negedge clk);
    btn_n = 1'b1;
    step(30);
    check("t6_rst_at_B69", sys_reset, 1);
    step(1);
    check("t6_rst_at_B70", sys_reset, 0);
    check("t6_loss", lock_loss_cnt, 0);
`endif

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
